// File: rtl/timer_multi.sv
// NUM_CH independent compare-match timers behind one slave-bus window, with an OR-reduced level irq.
// Optional per-channel clock prescaler (CTRL[15:8]) is built when TIMER_PRESCALE_EN is defined.

package timer_multi_pkg;

    typedef struct packed {
        logic irq_en;
        logic mode;
        logic start;
    } ctrl_t;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_INTR    = 2'd1;
    localparam logic [1:0] REG_EXPR    = 2'd2;
    localparam logic [1:0] REG_COUNTER = 2'd3;

endpackage

module timer_multi
    import timer_multi_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_AW  = 2,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cs_,
    input  logic                as_,
    input  logic                rw,
    input  logic [CH_AW+1:0]    addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rdy_,
    output logic                irq
);

    localparam int unsigned AW    = CH_AW + 2;
    localparam int unsigned PSC_W = 8;

    logic                access;
    logic                wr_en;
    logic                rd_en;
    logic [CH_AW-1:0]    ch_sel;
    logic [1:0]          reg_sel;

    ctrl_t               ctrl_q   [NUM_CH];
    ctrl_t               ctrl_d   [NUM_CH];
    logic                status_q [NUM_CH];
    logic                status_d [NUM_CH];
    logic [CNT_W-1:0]    expr_q   [NUM_CH];
    logic [CNT_W-1:0]    expr_d   [NUM_CH];
    logic [CNT_W-1:0]    cnt_q    [NUM_CH];
    logic [CNT_W-1:0]    cnt_d    [NUM_CH];

    logic                ch_wr    [NUM_CH];
    logic                tick     [NUM_CH];
    logic                expire   [NUM_CH];

    logic [DATA_W-1:0]   rd_val;
    logic                irq_d;

    logic [DATA_W-1:0]   rd_data_q;
    logic                rdy_q;
    logic                irq_q;

`ifdef TIMER_PRESCALE_EN
    logic [PSC_W-1:0]    psc_q    [NUM_CH];
    logic [PSC_W-1:0]    psc_d    [NUM_CH];
    logic [PSC_W-1:0]    pre_q    [NUM_CH];
    logic [PSC_W-1:0]    pre_d    [NUM_CH];
`endif

    assign access  = !cs_ && !as_;
    assign wr_en   = access && !rw;
    assign rd_en   = access && rw;
    assign ch_sel  = addr[AW-1:2];
    assign reg_sel = addr[1:0];

    // Channel write decode; indices >= NUM_CH never match, so such writes are dropped.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_wr[c] = wr_en && (ch_sel == CH_AW'(c));
        end
    end

    // Counting tick and compare-match per channel.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
`ifdef TIMER_PRESCALE_EN
            tick[c] = (pre_q[c] == psc_q[c]);
`else
            tick[c] = 1'b1;
`endif
            expire[c] = ctrl_q[c].start && (cnt_q[c] == expr_q[c]) && tick[c];
        end
    end

    // Per-channel next state; bus writes are applied last so they win collisions.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ctrl_d[c]   = ctrl_q[c];
            status_d[c] = status_q[c];
            expr_d[c]   = expr_q[c];
            cnt_d[c]    = cnt_q[c];

            if (expire[c]) begin
                cnt_d[c]    = '0;
                status_d[c] = 1'b1;
                if (!ctrl_q[c].mode) begin
                    ctrl_d[c].start = 1'b0;
                end
            end else if (ctrl_q[c].start && tick[c]) begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end

            if (ch_wr[c]) begin
                unique case (reg_sel)
                    REG_CTRL: begin
                        ctrl_d[c].start  = wr_data[0];
                        ctrl_d[c].mode   = wr_data[1];
                        ctrl_d[c].irq_en = wr_data[2];
                    end
                    REG_INTR: begin
                        if (wr_data[0] && !expire[c]) begin
                            status_d[c] = 1'b0;
                        end
                    end
                    REG_EXPR:    expr_d[c] = wr_data[CNT_W-1:0];
                    REG_COUNTER: cnt_d[c]  = wr_data[CNT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef TIMER_PRESCALE_EN
    // Prescaler restarts whenever the channel is stopped or reconfigured.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            psc_d[c] = psc_q[c];
            pre_d[c] = pre_q[c] + PSC_W'(1);
            if (ch_wr[c] && (reg_sel == REG_CTRL)) begin
                psc_d[c] = wr_data[15:8];
            end
            if (!ctrl_q[c].start || (ch_wr[c] && (reg_sel == REG_CTRL)) || tick[c]) begin
                pre_d[c] = '0;
            end
        end
    end
`endif

    // Read mux; unmatched channel indices read as zero.
    always_comb begin
        rd_val = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_sel == CH_AW'(c)) begin
                unique case (reg_sel)
`ifdef TIMER_PRESCALE_EN
                    REG_CTRL:    rd_val = DATA_W'({psc_q[c], 5'b0, ctrl_q[c]});
`else
                    REG_CTRL:    rd_val = DATA_W'(ctrl_q[c]);
`endif
                    REG_INTR:    rd_val = DATA_W'(status_q[c]);
                    REG_EXPR:    rd_val = DATA_W'(expr_q[c]);
                    REG_COUNTER: rd_val = DATA_W'(cnt_q[c]);
                    default:     rd_val = '0;
                endcase
            end
        end
    end

    always_comb begin
        irq_d = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            irq_d = irq_d | (status_q[c] & ctrl_q[c].irq_en);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
            rdy_q     <= 1'b1;
            irq_q     <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                ctrl_q[c]   <= '0;
                status_q[c] <= 1'b0;
                expr_q[c]   <= '0;
                cnt_q[c]    <= '0;
`ifdef TIMER_PRESCALE_EN
                psc_q[c]    <= '0;
                pre_q[c]    <= '0;
`endif
            end
        end else begin
            rd_data_q <= rd_en ? rd_val : '0;
            rdy_q     <= !access;
            irq_q     <= irq_d;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                ctrl_q[c]   <= ctrl_d[c];
                status_q[c] <= status_d[c];
                expr_q[c]   <= expr_d[c];
                cnt_q[c]    <= cnt_d[c];
`ifdef TIMER_PRESCALE_EN
                psc_q[c]    <= psc_d[c];
                pre_q[c]    <= pre_d[c];
`endif
            end
        end
    end

    assign rd_data = rd_data_q;
    assign rdy_    = rdy_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: table-driven bus sequences with a read-data scoreboard checked on every cycle.
// CH_AW = 3 so that channel indices 4..7 exist on the bus but have no timer behind them.

module tb_timer_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_AW  = 3;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned AW     = CH_AW + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cs_ = 1'b1;
    logic              as_ = 1'b1;
    logic              rw = 1'b1;
    logic [AW-1:0]     addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rdy_;
    logic              irq;

    timer_multi #(
        .NUM_CH (NUM_CH),
        .CH_AW  (CH_AW),
        .CNT_W  (CNT_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs_     (cs_),
        .as_     (as_),
        .rw      (rw),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rdy_    (rdy_),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned       idle;
        bit                rd;
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t              vecs[$];
    logic [DATA_W-1:0] sb[$];
    int                n_checks = 0;
    int                n_fail = 0;
    bit                mon_en = 1'b0;
    bit                mon_acc;
    logic [DATA_W-1:0] mon_exp;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] ra(input int unsigned ch, input int unsigned rg);
        return AW'(ch * 4 + rg);
    endfunction

    function automatic void w(input int unsigned idle, input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        vec_t e;
        e.idle = idle; e.rd = 1'b0; e.addr = a; e.wdata = d; e.exp = '0;
        vecs.push_back(e);
    endfunction

    function automatic void r(input int unsigned idle, input logic [AW-1:0] a, input logic [DATA_W-1:0] x);
        vec_t e;
        e.idle = idle; e.rd = 1'b1; e.addr = a; e.wdata = '0; e.exp = x;
        vecs.push_back(e);
    endfunction

    task automatic idle(input int unsigned n);
        cs_ = 1'b1;
        as_ = 1'b1;
        rw  = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One bus access sampled at the next rising edge; returns at the following falling edge.
    task automatic acc(input bit rd, input logic [AW-1:0] a, input logic [DATA_W-1:0] wd,
                       input logic [DATA_W-1:0] exp);
        cs_ = 1'b0;
        as_ = 1'b0;
        rw = rd;
        addr = a;
        wr_data = wd;
        sb.push_back(rd ? exp : '0);
        @(negedge clk);
        cs_ = 1'b1;
        as_ = 1'b1;
        rw = 1'b1;
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            idle(vecs[i].idle);
            acc(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        end
        vecs.delete();
    endtask

    // Every cycle: an access sampled at the edge must give rdy_ low and the queued data; otherwise idle outputs.
    always @(posedge clk) begin
        mon_acc = !cs_ && !as_ && !reset;
        #1;
        if (mon_en) begin
            if (mon_acc) begin
                chk("rdy_ on access", DATA_W'(rdy_), '0);
                if (sb.size() == 0) begin
                    chk("scoreboard underflow", 32'd0, 32'd1);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("rd_data", rd_data, mon_exp);
                end
            end else begin
                chk("rdy_ idle", DATA_W'(rdy_), 32'd1);
                chk("rd_data idle", rd_data, '0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset rdy_", DATA_W'(rdy_), 32'd1);
        chk("reset rd_data", rd_data, '0);
        chk("reset irq", DATA_W'(irq), '0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Reset values of ch0 and ch3.
        for (int unsigned rg = 0; rg < 4; rg++) begin
            r(0, ra(0, rg), '0);
            r(0, ra(3, rg), '0);
        end
        run_vecs();
        chk("irq after reset", DATA_W'(irq), '0);

        // ch1 one-shot, expr 9, irq enabled: status at the 10th edge after start.
        acc(0, ra(1, 2), 32'd9, '0);
        acc(0, ra(1, 0), 32'h5, '0);
        idle(9);
        acc(1, ra(1, 1), '0, 32'd0);
        chk("ch1 irq before expire", DATA_W'(irq), '0);
        acc(1, ra(1, 1), '0, 32'd1);
        chk("ch1 irq after expire", DATA_W'(irq), 32'd1);
        acc(1, ra(1, 3), '0, 32'd0);
        acc(1, ra(1, 0), '0, 32'h4);
        acc(0, ra(1, 1), 32'd1, '0);
        chk("ch1 irq same cycle as clear", DATA_W'(irq), 32'd1);
        idle(1);
        chk("ch1 irq after clear", DATA_W'(irq), '0);

        // ch2 periodic, expr 3, irq disabled.
        w(0, ra(2, 2), 32'd3);
        w(0, ra(2, 0), 32'h3);
        for (int k = 0; k < 8; k++) r(0, ra(2, 3), DATA_W'(k % 4));
        r(0, ra(2, 1), 32'd1);
        r(0, ra(2, 0), 32'h3);
        run_vecs();
        chk("ch2 irq masked", DATA_W'(irq), '0);
        acc(0, ra(2, 0), 32'h7, '0);
        chk("ch2 irq one cycle after enable", DATA_W'(irq), '0);
        idle(1);
        chk("ch2 irq enabled", DATA_W'(irq), 32'd1);
        acc(0, ra(2, 0), 32'h0, '0);
        acc(0, ra(2, 1), 32'h1, '0);
        idle(2);
        chk("ch2 irq stopped", DATA_W'(irq), '0);

        // ch0 periodic expr 4: INTR clear and COUNTER write landing on expire cycles.
        w(0, ra(0, 2), 32'd4);
        w(0, ra(0, 0), 32'h3);
        w(6, ra(0, 1), 32'd1);
        r(0, ra(0, 1), 32'd0);
        w(1, ra(0, 1), 32'd1);
        r(0, ra(0, 1), 32'd1);
        w(0, ra(0, 1), 32'd1);
        w(2, ra(0, 3), 32'd100);
        r(0, ra(0, 3), 32'd100);
        r(0, ra(0, 1), 32'd1);
        w(0, ra(0, 0), 32'h0);
        w(0, ra(0, 1), 32'd1);

        // ch0 wrap through zero without status, then expire at 5.
        w(0, ra(0, 3), 32'hFFFF_FFFE);
        w(0, ra(0, 2), 32'd5);
        w(0, ra(0, 0), 32'h1);
        r(0, ra(0, 3), 32'hFFFF_FFFE);
        r(0, ra(0, 3), 32'hFFFF_FFFF);
        r(0, ra(0, 3), 32'd0);
        r(0, ra(0, 1), 32'd0);
        r(3, ra(0, 1), 32'd0);
        r(0, ra(0, 1), 32'd1);
        r(0, ra(0, 0), 32'd0);
        w(0, ra(0, 1), 32'd1);

        // Channels beyond NUM_CH.
        w(0, ra(7, 0), 32'h7);
        r(0, ra(7, 0), 32'd0);
        w(0, ra(7, 2), 32'd5);
        r(0, ra(7, 2), 32'd0);
        r(0, ra(4, 0), 32'd0);

        // ch3 with CTRL[15:8] = 2, expr 1.
        w(0, ra(3, 2), 32'd1);
        w(0, ra(3, 0), 32'h0201);
`ifdef TIMER_PRESCALE_EN
        r(5, ra(3, 1), 32'd0);
        r(0, ra(3, 1), 32'd1);
        r(0, ra(3, 0), 32'h0200);
`else
        r(1, ra(3, 1), 32'd0);
        r(0, ra(3, 1), 32'd1);
        r(0, ra(3, 0), 32'h0000);
`endif
        w(0, ra(3, 1), 32'd1);
        run_vecs();
        chk("irq idle after table", DATA_W'(irq), '0);

        // Reset in the middle of running channel and a concurrent access.
        acc(0, ra(1, 2), 32'd2, '0);
        acc(0, ra(1, 0), 32'h7, '0);
        idle(5);
        chk("ch1 irq running", DATA_W'(irq), 32'd1);
        reset = 1'b1;
        cs_ = 1'b0;
        as_ = 1'b0;
        rw = 1'b1;
        addr = ra(1, 0);
        @(negedge clk);
        chk("mid reset rdy_", DATA_W'(rdy_), 32'd1);
        chk("mid reset irq", DATA_W'(irq), '0);
        reset = 1'b0;
        idle(1);
        acc(1, ra(1, 0), '0, 32'd0);
        acc(1, ra(1, 1), '0, 32'd0);
        acc(1, ra(1, 2), '0, 32'd0);
        acc(1, ra(1, 3), '0, 32'd0);

        idle(3);
        chk("scoreboard drained", DATA_W'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
